// File: rtl/writeback_stage_if.sv
// writeback_stage_if
//   Bundles the MEM/WB boundary of the MiniMIPS pipeline. It carries the
//   memory-stage results and the hazard controls into the writeback stage.
//   It carries the register-file write port, the forwarding port and the
//   retire counter back out.
// Modports
//   master : memory stage / hazard unit side (drives in_*, stall_i, flush_i)
//   slave  : writeback stage side (drives WE3/A3/WD3, wb_valid, fwd_*, retire_count)
interface writeback_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  stall_i;
    logic                  flush_i;
    logic                  in_valid;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;
    logic [1:0]            in_load_size;
    logic                  in_load_unsigned;
    logic [1:0]            in_byte_off;
    logic [DATA_WIDTH-1:0] in_alu_result;
    logic [DATA_WIDTH-1:0] in_mem_rdata;
    logic [ADDR_WIDTH-1:0] in_dest;

    logic                  WE3;
    logic [ADDR_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0] WD3;
    logic                  wb_valid;
    logic                  fwd_en;
    logic [ADDR_WIDTH-1:0] fwd_reg;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [CNT_WIDTH-1:0]  retire_count;

    modport master (
        output stall_i, flush_i, in_valid, in_reg_write, in_mem_to_reg,
               in_load_size, in_load_unsigned, in_byte_off, in_alu_result,
               in_mem_rdata, in_dest,
        input  WE3, A3, WD3, wb_valid, fwd_en, fwd_reg, fwd_data, retire_count
    );

    modport slave (
        input  stall_i, flush_i, in_valid, in_reg_write, in_mem_to_reg,
               in_load_size, in_load_unsigned, in_byte_off, in_alu_result,
               in_mem_rdata, in_dest,
        output WE3, A3, WD3, wb_valid, fwd_en, fwd_reg, fwd_data, retire_count
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage
//   MEM/WB pipeline register plus writeback logic for the MiniMIPS pipeline.
//   Load extraction (byte/half/word with sign or zero extension) and the
//   ALU/load select happen before the register. As a result, WD3 comes straight
//   from a flop and is stable half a cycle before the negedge regfile commit.
// Ports
//   clk  : pipeline clock, posedge captures
//   rst  : asynchronous, active-high reset; clears every stage register
//   wb   : writeback_stage_if.slave
//          inputs  - stall_i, flush_i, in_* memory-stage results
//          outputs - WE3/A3/WD3 regfile write port, wb_valid,
//                    fwd_en/fwd_reg/fwd_data (mirror of the write port),
//                    retire_count
// Configuration
//   WB_RETIRE_COUNT_EN : when defined, retire_count counts instructions that
//                        leave the stage. It wraps modulo 2^CNT_WIDTH.
//                        When undefined, retire_count is tied to 0.
module writeback_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  wb
);

    // Byte/half lane select followed by sign or zero extension. Sizes 10 and
    // 11 both pass the word through, and the unsigned flag is ignored for them.
    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [1:0]            size,
        input logic                  uns,
        input logic [1:0]            off
    );
        logic signed [7:0]      lane_b;
        logic signed [15:0]     lane_h;
        logic [DATA_WIDTH-1:0]  res;
        case (off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        // Misaligned halfwords are not trapped; off[0] simply drops out.
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   res = uns ? {{(DATA_WIDTH-8){1'b0}}, lane_b}
                           : {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
            2'b01:   res = uns ? {{(DATA_WIDTH-16){1'b0}}, lane_h}
                           : {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic                  valid_q,     valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] dest_q,      dest_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic [DATA_WIDTH-1:0] wb_value;

    always_comb begin
        wb_value = wb.in_mem_to_reg
                 ? load_extract(wb.in_mem_rdata, wb.in_load_size,
                                wb.in_load_unsigned, wb.in_byte_off)
                 : wb.in_alu_result;
    end

    // Flush beats stall, and stall beats capture.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        dest_d      = dest_q;
        data_d      = data_q;
        if (wb.flush_i) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            dest_d      = '0;
            data_d      = '0;
        end else if (!wb.stall_i) begin
            valid_d     = wb.in_valid;
            reg_write_d = wb.in_reg_write;
            dest_d      = wb.in_dest;
            data_d      = wb_value;
        end
    end

    // MEM/WB register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            dest_q      <= '0;
            data_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            dest_q      <= dest_d;
            data_q      <= data_d;
        end
    end

    // The regfile does not protect $zero, so writes to r0 are dropped here.
    // A3/WD3 still show the captured values.
    logic we;
    always_comb begin
        we = valid_q & reg_write_q & (dest_q != '0);
    end

    assign wb.WE3      = we;
    assign wb.A3       = dest_q;
    assign wb.WD3      = data_q;
    assign wb.wb_valid = valid_q;
    assign wb.fwd_en   = we;
    assign wb.fwd_reg  = dest_q;
    assign wb.fwd_data = data_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // An instruction retires on the edge where it leaves the stage. This is
    // the case when the stage is valid and is not being held.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !wb.stall_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb.retire_count = cnt_q;
`else
    assign wb.retire_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
    writeback_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2))  bus2 ();

    writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .wb  (bus2.slave)
    );

    // The narrow-counter instance sees the same stimulus.
    assign bus2.stall_i          = bus.stall_i;
    assign bus2.flush_i          = bus.flush_i;
    assign bus2.in_valid         = bus.in_valid;
    assign bus2.in_reg_write     = bus.in_reg_write;
    assign bus2.in_mem_to_reg    = bus.in_mem_to_reg;
    assign bus2.in_load_size     = bus.in_load_size;
    assign bus2.in_load_unsigned = bus.in_load_unsigned;
    assign bus2.in_byte_off      = bus.in_byte_off;
    assign bus2.in_alu_result    = bus.in_alu_result;
    assign bus2.in_mem_rdata     = bus.in_mem_rdata;
    assign bus2.in_dest          = bus.in_dest;

    // Negedge-committing regfile with no $zero protection.
    logic [31:0] rf [32];
    always @(negedge clk) begin
        if (bus.WE3 === 1'b1) rf[bus.A3] <= bus.WD3;
    end

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        valid;
        logic [31:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic        m_rw    = 1'b0;
    logic [4:0]  m_dest  = '0;
    logic [31:0] m_data  = '0;
    int unsigned m_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_value(input logic m2r, input logic [1:0] size,
                                              input logic uns, input logic [1:0] off,
                                              input logic [31:0] alu, input logic [31:0] rdata);
        logic [31:0] sh;
        if (!m2r) return alu;
        case (size)
            2'b00: begin
                sh = rdata >> (8 * int'(off));
                return uns ? {24'b0, sh[7:0]} : 32'($signed(sh[7:0]));
            end
            2'b01: begin
                sh = rdata >> (16 * int'(off[1]));
                return uns ? {16'b0, sh[15:0]} : 32'($signed(sh[15:0]));
            end
            default: return rdata;
        endcase
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.we    = m_valid & m_rw & (m_dest != 5'd0);
        e.a3    = m_dest;
        e.wd    = m_data;
        e.valid = m_valid;
`ifdef WB_RETIRE_COUNT_EN
        e.cnt   = m_cnt;
        e.cnt2  = m_cnt[1:0];
`else
        e.cnt   = 32'd0;
        e.cnt2  = 2'd0;
`endif
        return e;
    endfunction

    // Apply one cycle of stimulus and push what the stage must show after the next posedge.
    task automatic drive(input logic valid, input logic rw, input logic m2r,
                         input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [4:0] dest, input logic stall, input logic flush);
        bus.in_valid         = valid;
        bus.in_reg_write     = rw;
        bus.in_mem_to_reg    = m2r;
        bus.in_load_size     = size;
        bus.in_load_unsigned = uns;
        bus.in_byte_off      = off;
        bus.in_alu_result    = alu;
        bus.in_mem_rdata     = rdata;
        bus.in_dest          = dest;
        bus.stall_i          = stall;
        bus.flush_i          = flush;
        if (m_valid && !stall) m_cnt++;
        if (flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_dest = '0; m_data = '0;
        end else if (!stall) begin
            m_valid = valid; m_rw = rw; m_dest = dest;
            m_data  = ref_value(m2r, size, uns, off, alu, rdata);
        end
        sb.push_back(snapshot());
    endtask

    task automatic compare_now(input string tag, input exp_t e);
        check({tag, ".WE3"},      {31'b0, bus.WE3},       {31'b0, e.we});
        check({tag, ".A3"},       {27'b0, bus.A3},        {27'b0, e.a3});
        check({tag, ".WD3"},      bus.WD3,                e.wd);
        check({tag, ".wb_valid"}, {31'b0, bus.wb_valid},  {31'b0, e.valid});
        check({tag, ".fwd_en"},   {31'b0, bus.fwd_en},    {31'b0, e.we});
        check({tag, ".fwd_reg"},  {27'b0, bus.fwd_reg},   {27'b0, e.a3});
        check({tag, ".fwd_data"}, bus.fwd_data,           e.wd);
        check({tag, ".retire"},   bus.retire_count,       e.cnt);
        check({tag, ".retire2"},  {30'b0, bus2.retire_count}, {30'b0, e.cnt2});
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            compare_now(tag, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        bus.stall_i = 0; bus.flush_i = 0; bus.in_valid = 0; bus.in_reg_write = 0;
        bus.in_mem_to_reg = 0; bus.in_load_size = 0; bus.in_load_unsigned = 0;
        bus.in_byte_off = 0; bus.in_alu_result = 0; bus.in_mem_rdata = 0; bus.in_dest = 0;
        z = snapshot();

        #2;
        compare_now("reset", z);
        @(negedge clk);
        rst = 1'b0;

        // ALU result into $t1, then read it back from the regfile after the negedge
        drive(1, 1, 0, 2'b00, 0, 2'd0, 32'h0000_000C, 32'h0, 5'd9, 0, 0);
        cycle("alu");
        @(negedge clk); #1;
        check("rf_t1", rf[9], 32'd12);

        // Loads
        drive(1, 1, 1, 2'b00, 0, 2'd2, 32'h0, 32'h12F4_5680, 5'd10, 0, 0);
        cycle("lb_s_off2");
        drive(1, 1, 1, 2'b00, 1, 2'd2, 32'h0, 32'h12F4_5680, 5'd11, 0, 0);
        cycle("lbu_off2");
        drive(1, 1, 1, 2'b01, 0, 2'd3, 32'h0, 32'h12F4_5680, 5'd12, 0, 0);
        cycle("lh_s_off3");
        drive(1, 1, 1, 2'b01, 0, 2'd1, 32'h0, 32'h8000_ABCD, 5'd13, 0, 0);
        cycle("lh_s_off1");
        drive(1, 1, 1, 2'b01, 1, 2'd0, 32'h0, 32'h8000_ABCD, 5'd14, 0, 0);
        cycle("lhu_off0");
        drive(1, 1, 1, 2'b00, 0, 2'd3, 32'h0, 32'h8000_ABCD, 5'd15, 0, 0);
        cycle("lb_s_off3");
        drive(1, 1, 1, 2'b11, 1, 2'd1, 32'h0, 32'hCAFE_F00D, 5'd16, 0, 0);
        cycle("lw_size11");
        drive(1, 1, 0, 2'b00, 0, 2'd3, 32'h7654_3210, 32'hFFFF_FFFF, 5'd17, 0, 0);
        cycle("alu_ignores_size");

        // Write to $zero must be suppressed
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0);
        cycle("dest_zero");
        @(negedge clk); #1;
        check("rf_zero", rf[0], 32'd0);

        // Bubble and a non-writing instruction
        drive(0, 1, 0, 2'b10, 0, 2'd0, 32'h1111_1111, 32'h0, 5'd5, 0, 0);
        cycle("bubble");
        drive(1, 0, 0, 2'b10, 0, 2'd0, 32'h2222_2222, 32'h0, 5'd6, 0, 0);
        cycle("no_regwrite");

        // Stall holds for two cycles, then flush wins over stall
        drive(1, 1, 1, 2'b00, 0, 2'd1, 32'h0, 32'hA5A5_7F00, 5'd20, 0, 0);
        cycle("pre_stall");
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'h3333_3333, 32'h0, 5'd21, 1, 0);
        cycle("stall1");
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'h4444_4444, 32'h0, 5'd22, 1, 0);
        cycle("stall2");
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'h5555_5555, 32'h0, 5'd23, 1, 1);
        cycle("flush_stall");
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'h6666_6666, 32'h0, 5'd24, 0, 0);
        cycle("post_flush");
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'h7777_7777, 32'h0, 5'd25, 0, 1);
        cycle("flush_only");

        // Asynchronous reset mid-cycle drops the pending write immediately
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'h8888_8888, 32'h0, 5'd26, 0, 0);
        cycle("pre_reset");
        #2;
        rst = 1'b1;
        #1;
        m_valid = 0; m_rw = 0; m_dest = '0; m_data = '0; m_cnt = 0;
        sb.delete();
        compare_now("async_reset", snapshot());
        rst = 1'b0;

        // Retire counting: 5 valid, 1 bubble, 1 stalled cycle
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 2'b10, 0, 2'd0, 32'h100 + i, 32'h0, 5'(i + 1), 0, 0);
            cycle("retire_seq");
        end
        drive(0, 0, 0, 2'b10, 0, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0);
        cycle("retire_bubble");
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'h999, 32'h0, 5'd7, 1, 0);
        cycle("retire_stall");
        drive(0, 0, 0, 2'b10, 0, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0);
        cycle("retire_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
